// File: rtl/serial_101_framer_if.sv
// -----------------------------------------------------------------------------
// serial_101_framer_if
//
// Word handshake between a producer and serial_101_framer.
//
//   data  : WIDTH-bit word offered by the producer
//   valid : producer has a word on data
//   ready : framer can accept a word this cycle
//
// Modports:
//   master : producer side (drives data/valid, observes ready)
//   slave  : framer side   (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface serial_101_framer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/serial_101_framer.sv
// -----------------------------------------------------------------------------
// serial_101_framer
//
// Parallel-to-serial transmitter feeding the single-bit line of a downstream
// 101 sequence detector. One WIDTH-bit word is accepted per valid/ready
// handshake and sent MSB first, one bit per clock.
//
// Optional framing, selected by the macro SERIAL_101_FRAMER_PREAMBLE_EN:
//   defined   : frame = 1,0,1 marker + WIDTH data bits + 0,0 guard
//   undefined : frame = WIDTH data bits only
//
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high, overrides every other input
//   bus        : serial_101_framer_if.slave (data, valid in; ready out)
//                ready is high exactly when the framer is idle
//   a          : registered serial output line
//   busy       : high whenever a frame is in progress
//   frame_done : one-cycle pulse together with the last bit of a frame
//   frame_cnt  : number of completed frames, wraps 255 -> 0
//
// Parameter:
//   WIDTH      : data word width, 2..32
// -----------------------------------------------------------------------------
module serial_101_framer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_101_framer_if.slave   bus,
  output logic                 a,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt
);

  // Index of the last data bit within the DATA state.
  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DATA  = 2'd2,
    S_GUARD = 2'd3
  } state_t;
`else
  // Without framing only the idle and data phases exist.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // Data index that precedes the LSB; frame_done is raised when leaving it.
  localparam logic [4:0] PENULT_IDX = 5'(WIDTH - 2);
`endif

  state_t           state_q, state_d;
  logic [4:0]       idx_q,   idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             a_q,     a_d;
  logic             fd_q,    fd_d;
  logic [7:0]       cnt_q,   cnt_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      a_q     <= 1'b0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  //
  // The line is registered, so a_d is always the bit that belongs to the
  // state being entered. shift_q holds the data bits not yet placed on the
  // line; its MSB is the next data bit to send.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    a_d     = 1'b0;
    fd_d    = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        // ready is implied by being in IDLE
        if (bus.valid) begin
          idx_d = '0;
`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
          // First marker bit goes out now; the word waits in the shifter.
          state_d = S_PRE;
          shift_d = bus.data;
          a_d     = 1'b1;
`else
          // MSB goes out immediately; keep the remaining bits.
          state_d = S_DATA;
          shift_d = {bus.data[WIDTH-2:0], 1'b0};
          a_d     = bus.data[WIDTH-1];
`endif
        end
      end

`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
      S_PRE: begin
        if (idx_q == 5'd2) begin
          // Marker complete: place the data MSB on the line.
          state_d = S_DATA;
          idx_d   = '0;
          a_d     = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
          // Marker positions 1 and 2 carry 0 then 1.
          idx_d = idx_q + 5'd1;
          a_d   = (idx_q == 5'd1);
        end
      end
`endif

      S_DATA: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
          // Guard zeros keep a data tail of 1,0 from forming a 101 with
          // the next frame's marker.
          state_d = S_GUARD;
`else
          state_d = S_IDLE;
          cnt_d   = cnt_q + 8'd1;
`endif
        end else begin
          idx_d   = idx_q + 5'd1;
          a_d     = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
`ifndef SERIAL_101_FRAMER_PREAMBLE_EN
          // The bit being loaded is the LSB, i.e. the last bit of the frame.
          fd_d    = (idx_q == PENULT_IDX);
`endif
        end
      end

`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
      S_GUARD: begin
        if (idx_q == 5'd0) begin
          // Second guard zero is the last bit of the frame.
          idx_d = 5'd1;
          fd_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = cnt_q + 8'd1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, no path from valid.
  // ---------------------------------------------------------------------------
  assign bus.ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign a          = a_q;
  assign frame_done = fd_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_101_framer.sv
module tb_serial_101_framer;

  localparam int W = 8;
`ifdef SERIAL_101_FRAMER_PREAMBLE_EN
  localparam int PRE_LEN = 3;
  localparam int GRD_LEN = 2;
  // Hand-derived line patterns, first bit in the MSB position.
  localparam logic [31:0] EXP_A5 = 32'h1694; // 101 10100101 00
  localparam logic [31:0] EXP_00 = 32'h1400; // 101 00000000 00
  localparam logic [31:0] EXP_81 = 32'h1604; // 101 10000001 00
  localparam int DET_A5 = 3;
  localparam int DET_00 = 1;
`else
  localparam int PRE_LEN = 0;
  localparam int GRD_LEN = 0;
  localparam logic [31:0] EXP_A5 = 32'hA5;
  localparam logic [31:0] EXP_00 = 32'h00;
  localparam logic [31:0] EXP_81 = 32'h81;
  localparam int DET_A5 = 2;
  localparam int DET_00 = 0;
`endif
  localparam int FLEN = PRE_LEN + W + GRD_LEN;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, busy, frame_done;
  logic [7:0] frame_cnt;

  serial_101_framer_if #(.WIDTH(W)) bus ();

  serial_101_framer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .a          (a),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is a list of bits built from the rules; the line
  // plays that list one bit per cycle, then one idle cycle bumps the count.
  // ---------------------------------------------------------------------------
  bit m_busy = 1'b0, m_a = 1'b0, m_fd = 1'b0;
  int m_cnt = 0;
  bit m_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_a = 1'b0; m_fd = 1'b0; m_cnt = 0; m_q.delete();
    end else if (m_busy) begin
      if (m_fd) begin
        m_cnt = (m_cnt + 1) % 256; m_busy = 1'b0; m_a = 1'b0; m_fd = 1'b0;
      end else begin
        m_a = m_q.pop_front(); m_fd = (m_q.size() == 0);
      end
    end else if (bus.valid === 1'b1) begin
      m_q.delete();
      if (PRE_LEN > 0) begin m_q.push_back(1'b1); m_q.push_back(1'b0); m_q.push_back(1'b1); end
      for (int i = W - 1; i >= 0; i--) m_q.push_back(bus.data[i]);
      for (int i = 0; i < GRD_LEN; i++) m_q.push_back(1'b0);
      m_a = m_q.pop_front(); m_fd = (m_q.size() == 0); m_busy = 1'b1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a", a, m_a);
      check("ready", bus.ready, !m_busy);
      check("busy", busy, m_busy);
      check("frame_done", frame_done, m_fd);
      check("frame_cnt", frame_cnt, 32'(m_cnt));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int t = 0;
    while (bus.ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (bus.ready !== 1'b1) check("ready_timeout", bus.ready, 1);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_ready();
    bus.data  = d;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.data  = W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int count_101(input bit b[$]);
    int n = 0;
    for (int i = 0; i + 2 < b.size(); i++)
      if (b[i] && !b[i+1] && b[i+2]) n++;
    return n;
  endfunction

  task automatic send_capture(input logic [W-1:0] d, input logic [31:0] exp_bits,
                              input int exp_det, input string tag);
    bit          bits[$];
    int          rlow = 0, nfd = 0, fd_pos = -1;
    logic [31:0] pv = '0;
    logic [7:0]  cnt0;
    cnt0 = frame_cnt;
    send(d);
    for (int i = 0; i < FLEN + 2; i++) begin
      bits.push_back(a);
      if (bus.ready === 1'b0) rlow++;
      if (frame_done === 1'b1) begin nfd++; fd_pos = i; end
      @(negedge clk);
    end
    for (int i = 0; i < FLEN; i++) pv = {pv[30:0], bits[i]};
    $display("frame %s data=%0h line=%0h", tag, d, pv);
    check({tag, "_bits"}, pv, exp_bits);
    check({tag, "_tail"}, 32'({bits[FLEN], bits[FLEN+1]}), 0);
    check({tag, "_fd_pulses"}, nfd, 1);
    check({tag, "_fd_pos"}, fd_pos, FLEN - 1);
    check({tag, "_ready_low"}, rlow, FLEN);
    check({tag, "_det"}, count_101(bits), exp_det);
    check({tag, "_cnt"}, frame_cnt, 32'(cnt0 + 8'd1));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int nfd, idle, t;
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state
    check("rst_a", a, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);

    // Single frames
    send_capture(8'hA5, EXP_A5, DET_A5, "A5");
    check("first_cnt", frame_cnt, 1);
    send_capture(8'h00, EXP_00, DET_00, "00");
    send_capture(8'h81, EXP_81, count_101('{1'b1}) + ((PRE_LEN > 0) ? 1 : 0), "81");

    // valid held high: back-to-back frames with exactly one idle cycle
    do_reset();
    bus.data  = 8'hFF;
    bus.valid = 1'b1;
    nfd = 0; idle = 0; t = 0;
    while (nfd < 3 && t < 200) begin
      @(negedge clk); t++;
      if (frame_done === 1'b1) nfd++;
      if (bus.ready === 1'b1) idle++;
    end
    bus.valid = 1'b0;
    @(negedge clk);
    $display("held valid: frames=%0d idle_cycles=%0d cnt=%0d", nfd, idle, frame_cnt);
    check("held_frames", nfd, 3);
    check("held_idle", idle, 2);
    check("held_cnt", frame_cnt, 3);

    // Reset on the 5th bit, with valid raised alongside reset
    send(8'hA5);
    repeat (4) @(negedge clk);
    reset     = 1'b1;
    bus.valid = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.valid = 1'b0;
    $display("mid-frame reset: a=%0b ready=%0b cnt=%0d", a, bus.ready, frame_cnt);
    check("mr_a", a, 0);
    check("mr_ready", bus.ready, 1);
    check("mr_busy", busy, 0);
    check("mr_fd", frame_done, 0);
    check("mr_cnt", frame_cnt, 0);
    send_capture(8'hA5, EXP_A5, DET_A5, "A5_after_reset");

    // 256 back-to-back frames: counter wraps on the 256th completion
    do_reset();
    bus.valid = 1'b1;
    nfd = 0; t = 0;
    while (nfd < 256 && t < 256 * (FLEN + 1) + 100) begin
      bus.data = W'($urandom);
      @(negedge clk); t++;
      if (frame_done === 1'b1) begin
        nfd++;
        bus.data = W'($urandom);
        @(negedge clk); t++;
        if (nfd == 255) check("cnt_255", frame_cnt, 255);
        if (nfd == 256) check("cnt_wrap", frame_cnt, 0);
      end
    end
    bus.valid = 1'b0;
    $display("wrap run: frames=%0d cnt=%0d", nfd, frame_cnt);
    check("wrap_frames", nfd, 256);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_101_framer.md
# serial_101_framer

Parallel-to-serial transmitter that drives the single-bit `a` line consumed by the team's 101 sequence detector. It accepts one `WIDTH`-bit word per valid/ready handshake and shifts it out MSB first, one bit per clock. Each frame is prefixed with a `101` sync marker and followed by a zero guard, so a downstream 101 detector marks frame starts. The block sits between a word-producing controller and the serial link.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high; has priority over every other input.
- `data`, input, `WIDTH`: word to send; sampled only on the handshake edge.
- `valid`, input, 1: producer has a word.
- `ready`, output, 1: block can accept a word; high exactly when the state is IDLE.
- `a`, output, 1: serial line, registered.
- `busy`, output, 1: high in every non-IDLE state.
- `frame_done`, output, 1: one-cycle pulse coincident with the last bit of a frame.
- `frame_cnt`, output, 8: count of completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, PRE (3 bits), DATA (`WIDTH` bits), GUARD (2 bits). A 5-bit bit index counts positions within the current state.
- IDLE: `a`=0, `ready`=1.
  - On `valid && ready` at an edge, the block loads `data` into the shift register and enters PRE with index 0.
- PRE: drives `a` = 1, 0, 1 over three cycles, then enters DATA.
- DATA: drives `a` = shift register MSB. The register shifts left each cycle. After `WIDTH` bits it enters GUARD.
- GUARD: drives `a`=0 for two cycles, then returns to IDLE.
  - `frame_done`=1 during the second guard cycle.
  - `frame_cnt` increments on the edge leaving that cycle.
  - The two zeros guarantee that no false `101` straddles the frame boundary, whatever the data tail.
- `valid` outside IDLE is ignored and causes no queuing. `data` may change freely except at the handshake edge.
- `valid` asserted in the same cycle as `reset` is ignored.
- Reset, at any point including mid-frame: at the next edge the block forces IDLE, `a`=0, index 0, shift register 0, `frame_cnt`=0. `frame_done` is 0 and the partial frame is abandoned.
- Reset values: `a`=0, `ready`=1, `busy`=0, `frame_done`=0, `frame_cnt`=0.

## Timing
- Handshake at edge E0. The first frame bit is visible on `a` after E0.
- With the preamble compiled in:
  - Preamble occupies E0..E2.
  - Data MSB appears after E3; data LSB after E(2+`WIDTH`).
  - Guard bits follow after E(3+`WIDTH`) and E(4+`WIDTH`).
  - IDLE and `ready`=1 return after E(5+`WIDTH`).
- Frame length is 5+`WIDTH` cycles. The minimum handshake-to-handshake period is 6+`WIDTH` cycles, because one IDLE cycle is mandatory.
- `ready`, `busy` and `frame_done` change only at rising edges, with no combinational path from `valid`.
- A `valid` held continuously produces back-to-back frames separated by exactly one IDLE `a`=0 cycle.

## Configuration
- Macro: `SERIAL_101_FRAMER_PREAMBLE_EN`.
- Defined: PRE and GUARD states are present, with behaviour as above.
- Undefined: PRE and GUARD are removed.
  - The handshake at E0 moves directly to DATA, so the MSB is visible after E0.
  - `frame_done` coincides with the LSB. IDLE returns after E(`WIDTH`).
  - Frame length is `WIDTH` cycles; the minimum period is `WIDTH`+1.
  - All other behaviour is unchanged.

## Test plan
- Macro defined, `WIDTH`=8, one handshake with `data`=8'hA5:
  - `a` = 1,0,1, 1,0,1,0,0,1,0,1, 0,0, then 0.
  - `frame_done` is high only on the 13th bit.
  - `frame_cnt` goes 0 -> 1.
  - `ready` is low for 13 cycles.
- Feed the same stream into the 101 detector: its output `w` pulses once per frame.
  - With `data`=8'h00 it pulses exactly once.
  - With `data`=8'hA5 it pulses 3 times: preamble, plus two in-data matches, and none across the boundary.
- `valid` held high with `data`=8'hFF for 3 frames:
  - Frames are separated by exactly one IDLE cycle.
  - `frame_cnt` = 3.
  - `valid` pulses while `busy` is high are not accepted.
- `reset` asserted on the 5th bit of a frame:
  - Next cycle: `a`=0, `ready`=1, `frame_cnt`=0, no `frame_done`.
  - A new handshake then emits a correct full frame.
- 256 back-to-back frames: `frame_cnt` wraps to 0 on the 256th completion.
- Macro undefined, `data`=8'h81:
  - `a` = 1,0,0,0,0,0,0,1, with `frame_done` on the 8th bit.
  - `ready` returns after 8 cycles.
